cache_mem_arbiter: RTL
======================

Name: cache_mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-cache and data-cache fill/writeback requests of up to two cores.
- One request at a time is latched and held until RAM signals ACCESS; the result is then returned to that requester only.
- Data requests have priority over instruction requests. Between cores, a round-robin pointer alternates after every completed grant.
- Sits between the per-core caches and the RAM model, in the memory-control position.

Parameters:
- CPUS, 2, number of cores served (legal values 1 or 2)
- WORD_W, 32, data and address width

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  CPUS  per-core instruction read request
- iaddr  in  CPUS x WORD_W  per-core instruction address
- iwait  out  CPUS  per-core instruction wait; 0 = data valid this cycle
- iload  out  CPUS x WORD_W  per-core instruction read data
- dREN  in  CPUS  per-core data read request
- dWEN  in  CPUS  per-core data write request
- daddr  in  CPUS x WORD_W  per-core data address
- dstore  in  CPUS x WORD_W  per-core write data
- dwait  out  CPUS  per-core data wait; 0 = access done this cycle
- dload  out  CPUS x WORD_W  per-core data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Reset state: IDLE, rr pointer = 0, grant register = 0. All iwait/dwait = 1. ramREN/ramWEN = 0. ramaddr/ramstore = 0.
- Loads: iload[c] and dload[c] are driven combinationally from ramload at all times. Data is meaningful only when the matching wait is 0.
- States: IDLE and GRANT.
- IDLE, selection: choose among asserted requests, then register grant {core, is_data} and go to GRANT.
  - Order: data requests (dREN|dWEN) of core rr; data of core !rr; instr of core rr; instr of core !rr.
  - No request: stay IDLE. RAM enables are 0 and all waits are 1 in IDLE.
- GRANT, RAM drive: ramaddr, ramstore, ramREN and ramWEN come from the granted requester.
  - If dREN and dWEN are both high, treat as write: ramWEN = 1, ramREN = 0.
  - Instruction grant: ramREN = 1, ramWEN = 0, ramstore = 0.
- GRANT, completion: on ramstate == ACCESS, the granted wait output is 0 in that same cycle (combinational). Next state is IDLE, and rr toggles when CPUS == 2.
- GRANT, abort: if the granted request deasserts before ACCESS, return to IDLE. No wait is deasserted and rr is unchanged.
- GRANT, other states: BUSY or FREE keeps GRANT with the request held. ERROR keeps GRANT and retries, i.e. the request stays driven.
- Latency:
  - A request first seen at cycle 0 in IDLE drives RAM from cycle 1.
  - Minimum completion is cycle 1, if RAM answers ACCESS immediately.
  - There is 1 IDLE bubble between back-to-back grants.
- Address or data changing during GRANT passes through unregistered. Caches must hold them stable.
- CPUS == 1: rr is forced to 0 and core-1 logic is absent.
- Reset asserted mid-grant: immediately IDLE, all waits 1, RAM enables 0. The in-flight access is dropped.
- Exactly one wait output per cycle may be 0.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined: adds output ports igrants (WORD_W) and dgrants (WORD_W).
  - They count completed instruction and data grants across all cores.
  - Increment on the ACCESS cycle; saturate at all-ones; reset to 0.
- Undefined: the ports and counters are absent. Arbitration is identical.

Test Plan:
- Core0 iREN=1, iaddr=0x40; RAM returns ACCESS 2 cycles after ramREN, ramload=0x8C220004 -> ramaddr=0x40 from cycle 1; iwait[0]=0 for exactly one cycle with iload[0]=0x8C220004; back to IDLE.
- Same cycle: core0 iREN (0x10) and core0 dWEN (daddr=0x200, dstore=0xDEADBEEF) -> data first: ramWEN=1, ramaddr=0x200. After its ACCESS, the instruction is served at 0x10.
- Both cores dREN continuously, rr=0 -> grant order core0, core1, core0, core1; dwait pulses alternate.
- Granted core1 dREN drops while ramstate=BUSY -> IDLE next cycle; dwait[1] never 0; rr unchanged.
- Reset pulsed mid-GRANT with ramstate=BUSY -> ramREN=0, all waits 1, state IDLE on the next edge.
- ARB_PERF_CNT_EN defined: 3 instruction and 2 data completions -> igrants=3, dgrants=2; ERROR cycles do not increment.

Source files
------------

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle of the cache/memory arbiter.
// The slave modport is the arbiter's view; the master modport drives caches and RAM model.
interface cache_mem_arbiter_if #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
);
    logic [CPUS-1:0]              iREN;
    logic [CPUS-1:0][WORD_W-1:0]  iaddr;
    logic [CPUS-1:0]              iwait;
    logic [CPUS-1:0][WORD_W-1:0]  iload;
    logic [CPUS-1:0]              dREN;
    logic [CPUS-1:0]              dWEN;
    logic [CPUS-1:0][WORD_W-1:0]  daddr;
    logic [CPUS-1:0][WORD_W-1:0]  dstore;
    logic [CPUS-1:0]              dwait;
    logic [CPUS-1:0][WORD_W-1:0]  dload;
    logic                         ramREN;
    logic                         ramWEN;
    logic [WORD_W-1:0]            ramaddr;
    logic [WORD_W-1:0]            ramstore;
    logic [WORD_W-1:0]            ramload;
    logic [1:0]                   ramstate;

    // Handshake: a cache holds its request (and address/data) asserted until its
    // wait output reads 0 for one cycle; dropping the request earlier aborts it.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between per-core I/D caches: data before instruction, round-robin across cores.
// Optional macro ARB_PERF_CNT_EN adds saturating completed-grant counters igrants/dgrants.
module cache_mem_arbiter #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    cache_mem_arbiter_if.slave  bus,
    output logic                dbg_state,
    output logic                dbg_rr
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [WORD_W-1:0]   igrants,
    output logic [WORD_W-1:0]   dgrants
`endif
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t state, next_state;
    logic   rr;
    logic   grant_core, grant_data;
    logic   sel_valid, sel_core, sel_data;
    logic   active, complete;

    // Request vectors padded to two cores so a single-core build needs no special indexing.
    logic [1:0]             i_req, d_rd, d_wr, d_req;
    logic [1:0][WORD_W-1:0] iaddr_p, daddr_p, dstore_p;
    logic [1:0]             iwait_p, dwait_p;

    always_comb begin
        i_req    = '0;
        d_rd     = '0;
        d_wr     = '0;
        iaddr_p  = '0;
        daddr_p  = '0;
        dstore_p = '0;
        for (int c = 0; c < CPUS; c++) begin
            i_req[c]    = bus.iREN[c];
            d_rd[c]     = bus.dREN[c];
            d_wr[c]     = bus.dWEN[c];
            iaddr_p[c]  = bus.iaddr[c];
            daddr_p[c]  = bus.daddr[c];
            dstore_p[c] = bus.dstore[c];
        end
    end

    assign d_req = d_rd | d_wr;

    always_comb begin
        sel_valid = 1'b1;
        sel_core  = rr;
        sel_data  = 1'b1;
        if (d_req[rr]) begin
            sel_core = rr;
            sel_data = 1'b1;
        end else if (d_req[~rr]) begin
            sel_core = ~rr;
            sel_data = 1'b1;
        end else if (i_req[rr]) begin
            sel_core = rr;
            sel_data = 1'b0;
        end else if (i_req[~rr]) begin
            sel_core = ~rr;
            sel_data = 1'b0;
        end else begin
            sel_valid = 1'b0;
        end
    end

    assign active   = grant_data ? d_req[grant_core] : i_req[grant_core];
    assign complete = (state == GRANT) && active && (bus.ramstate == RAM_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            rr         <= 1'b0;
            grant_core <= 1'b0;
            grant_data <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && sel_valid) begin
                grant_core <= (CPUS == 2) ? sel_core : 1'b0;
                grant_data <= sel_data;
            end
            if (complete && CPUS == 2)
                rr <= ~rr;
        end
    end

    // An abort (request dropped) wins over a simultaneous ACCESS: the RAM enables already fell.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sel_valid) next_state = GRANT;
            GRANT:   if (!active || complete) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        iwait_p      = 2'b11;
        dwait_p      = 2'b11;
        if (state == GRANT) begin
            if (grant_data) begin
                bus.ramWEN   = d_wr[grant_core];
                bus.ramREN   = d_rd[grant_core] & ~d_wr[grant_core];
                bus.ramaddr  = daddr_p[grant_core];
                bus.ramstore = dstore_p[grant_core];
                if (complete) dwait_p[grant_core] = 1'b0;
            end else begin
                bus.ramREN  = i_req[grant_core];
                bus.ramaddr = iaddr_p[grant_core];
                if (complete) iwait_p[grant_core] = 1'b0;
            end
        end
    end

    assign bus.iwait = iwait_p[CPUS-1:0];
    assign bus.dwait = dwait_p[CPUS-1:0];

    for (genvar c = 0; c < CPUS; c++) begin : g_load
        assign bus.iload[c] = bus.ramload;
        assign bus.dload[c] = bus.ramload;
    end

    assign dbg_state = (state == GRANT);
    assign dbg_rr    = rr;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            igrants <= '0;
            dgrants <= '0;
        end else if (complete) begin
            if (grant_data) begin
                if (dgrants != '1) dgrants <= dgrants + 1'b1;
            end else begin
                if (igrants != '1) igrants <= igrants + 1'b1;
            end
        end
    end
`endif

endmodule
